// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage.
package decode_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALUOP_W = 4;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU op encoding: {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Decoder output for one instruction word
    typedef struct packed {
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_imm;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               branch;
        logic               jump;
        logic               illegal;
        logic               uses_rs1;
        logic               uses_rs2;
    } dec_t;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rs1_val;
        logic [DATA_W-1:0]  rs2_val;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_imm;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               branch;
        logic               jump;
        logic               illegal;
    } idex_t;

    // Register read with write-back forwarding; x0 always reads zero
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rdata,
        input logic              we,
        input logic [REG_AW-1:0] wrd,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == '0)
            return '0;
        else if (we && (wrd == addr))
            return wdata;
        else
            return rdata;
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I decode and immediate generation.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_instr,
    output dec_t              o_dec_c
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7b5;
    imm_fmt_e   w_fmt;
    dec_t       w_ctrl;
    logic [DATA_W-1:0] w_imm;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_f7b5   = i_instr[30];

    // Control decode per opcode
    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = ALU_ADD;
        w_ctrl.rd     = i_instr[11:7];
        w_fmt         = IMM_NONE;
        case (w_opcode)
            OPC_OP: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = {w_f7b5, w_funct3};
                w_ctrl.uses_rs1  = 1'b1;
                w_ctrl.uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.uses_rs1    = 1'b1;
                w_fmt              = IMM_I;
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
                    w_ctrl.alu_op = {w_f7b5, w_funct3};
                else
                    w_ctrl.alu_op = {1'b0, w_funct3};
            end
            OPC_LOAD: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.uses_rs1    = 1'b1;
                w_fmt              = IMM_I;
            end
            OPC_STORE: begin
                w_ctrl.rd          = '0;
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.uses_rs1    = 1'b1;
                w_ctrl.uses_rs2    = 1'b1;
                w_fmt              = IMM_S;
            end
            OPC_BRANCH: begin
                // funct3 carried so execute can select the comparison
                w_ctrl.rd       = '0;
                w_ctrl.branch   = 1'b1;
                w_ctrl.alu_op   = {1'b0, w_funct3};
                w_ctrl.uses_rs1 = 1'b1;
                w_ctrl.uses_rs2 = 1'b1;
                w_fmt           = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_fmt              = IMM_U;
            end
            OPC_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_fmt            = IMM_J;
            end
            OPC_JALR: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.jump        = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.uses_rs1    = 1'b1;
                w_fmt              = IMM_I;
            end
            default: begin
                w_ctrl.illegal = 1'b1;
            end
        endcase
        if (w_ctrl.rd == '0)
            w_ctrl.reg_write = 1'b0;
    end

    // Sign-extended immediate per format
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_I:   w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Merge control and immediate
    always_comb begin
        o_dec_c     = w_ctrl;
        o_dec_c.imm = w_imm;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: ID/EX register, handshakes, load-use stall, WB bypass.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    output logic                    if_ready,
    input  logic [XLEN-1:0]         if_instr,
    input  logic [XLEN-1:0]         if_pc,
    output logic [$clog2(NREG)-1:0] rs1_addr,
    output logic [$clog2(NREG)-1:0] rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [XLEN-1:0]         ex_pc,
    output logic [XLEN-1:0]         ex_rs1_val,
    output logic [XLEN-1:0]         ex_rs2_val,
    output logic [XLEN-1:0]         ex_imm,
    output logic [$clog2(NREG)-1:0] ex_rd,
    output logic [3:0]              ex_alu_op,
    output logic                    ex_alu_src_imm,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_reg_write,
    output logic                    ex_branch,
    output logic                    ex_jump,
    output logic                    ex_illegal,
    output logic [31:0]             bubble_count
);

    dec_t              w_dec;
    idex_t             w_next;
    logic [REG_AW-1:0] w_rs1_addr;
    logic [REG_AW-1:0] w_rs2_addr;
    logic              w_hazard;
    logic              w_accept;

    idex_t             r_ex;
    logic              r_ex_valid;
    logic [31:0]       r_bubble_count;

    instr_decoder u_dec (
        .i_instr (if_instr),
        .o_dec_c (w_dec)
    );

    assign w_rs1_addr = if_instr[19:15];
    assign w_rs2_addr = if_instr[24:20];
    assign rs1_addr   = w_rs1_addr;
    assign rs2_addr   = w_rs2_addr;

    // Load-use: the load in EX writes a register the incoming instruction reads
    assign w_hazard = if_valid && r_ex_valid && r_ex.mem_read && (r_ex.rd != '0) &&
                      ((w_dec.uses_rs1 && (r_ex.rd == w_rs1_addr)) ||
                       (w_dec.uses_rs2 && (r_ex.rd == w_rs2_addr)));

    assign if_ready = (!r_ex_valid || ex_ready) && !w_hazard && !flush;
    assign w_accept = if_valid && if_ready;

    // Assemble the next ID/EX payload with forwarded operands
    always_comb begin
        w_next             = '0;
        w_next.pc          = if_pc;
        w_next.rs1_val     = bypass_read(w_rs1_addr, rs1_data, wb_we, wb_rd, wb_data);
        w_next.rs2_val     = bypass_read(w_rs2_addr, rs2_data, wb_we, wb_rd, wb_data);
        w_next.imm         = w_dec.imm;
        w_next.rd          = w_dec.rd;
        w_next.alu_op      = w_dec.alu_op;
        w_next.alu_src_imm = w_dec.alu_src_imm;
        w_next.mem_read    = w_dec.mem_read;
        w_next.mem_write   = w_dec.mem_write;
        w_next.reg_write   = w_dec.reg_write;
        w_next.branch      = w_dec.branch;
        w_next.jump        = w_dec.jump;
        w_next.illegal     = w_dec.illegal;
    end

    // ID/EX register: flush beats accept, accept beats drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_next;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Saturating load-use bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_bubble_count <= '0;
        else if (w_hazard && ex_ready && !flush && (r_bubble_count != '1))
            r_bubble_count <= r_bubble_count + 32'd1;
    end

    assign ex_valid       = r_ex_valid;
    assign ex_pc          = r_ex.pc;
    assign ex_rs1_val     = r_ex.rs1_val;
    assign ex_rs2_val     = r_ex.rs2_val;
    assign ex_imm         = r_ex.imm;
    assign ex_rd          = r_ex.rd;
    assign ex_alu_op      = r_ex.alu_op;
    assign ex_alu_src_imm = r_ex.alu_src_imm;
    assign ex_mem_read    = r_ex.mem_read;
    assign ex_mem_write   = r_ex.mem_write;
    assign ex_reg_write   = r_ex.reg_write;
    assign ex_branch      = r_ex.branch;
    assign ex_jump        = r_ex.jump;
    assign ex_illegal     = r_ex.illegal;
    assign bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_imm;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;
    logic [31:0] bubble_count;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_rs1_val     (ex_rs1_val),
        .ex_rs2_val     (ex_rs2_val),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_alu_op      (ex_alu_op),
        .ex_alu_src_imm (ex_alu_src_imm),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_illegal     (ex_illegal),
        .bubble_count   (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: {alu_src_imm, mem_read, mem_write, reg_write, branch, jump, illegal}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic [3:0]  e_alu;
        logic [6:0]  e_ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [31:0] ins,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] eimm, input logic [4:0] erd,
                           input logic [3:0] ealu, input logic [6:0] ectrl);
        vec_t v;
        v.name = nm; v.instr = ins; v.rs1d = r1; v.rs2d = r2;
        v.wbwe = we; v.wbrd = wrd; v.wbdata = wd;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_imm = eimm; v.e_rd = erd;
        v.e_alu = ealu; v.e_ctrl = ectrl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
                ex_branch, ex_jump, ex_illegal};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_bubble", bubble_count, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_ctrl", 32'(ctrl_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_if_ready", 32'(if_ready), 32'd1);

        add_vec("addi",    32'h00500093, 32'h1234, 32'h55, 1'b1, 5'd0, 32'hFFFF,
                32'h0, 32'h55, 32'd5, 5'd1, 4'h0, 7'b1001000);
        add_vec("add_byp", 32'h00018233, 32'h0, 32'h99, 1'b1, 5'd3, 32'hDEAD,
                32'hDEAD, 32'h0, 32'h0, 5'd4, 4'h0, 7'b0001000);
        add_vec("sub",     32'h402082B3, 32'd10, 32'd3, 1'b1, 5'd7, 32'hBAD,
                32'd10, 32'd3, 32'h0, 5'd5, 4'h8, 7'b0001000);
        add_vec("srai",    32'h4030D313, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h80000000, 32'h0, 32'h403, 5'd6, 4'hD, 7'b1001000);
        add_vec("xori",    32'hFFF0C393, 32'h1, 32'h31, 1'b0, 5'd0, 32'h0,
                32'h1, 32'h31, 32'hFFFFFFFF, 5'd7, 4'h4, 7'b1001000);
        add_vec("lw",      32'h00812283, 32'h1000, 32'h22, 1'b0, 5'd0, 32'h0,
                32'h1000, 32'h22, 32'd8, 5'd5, 4'h0, 7'b1101000);
        add_vec("sw_byp",  32'hFE612E23, 32'h2000, 32'h11, 1'b1, 5'd6, 32'hCAFE,
                32'h2000, 32'hCAFE, 32'hFFFFFFFC, 5'd0, 4'h0, 7'b1010000);
        add_vec("beq",     32'hFE208CE3, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0,
                32'h3, 32'h4, 32'hFFFFFFF8, 5'd0, 4'h0, 7'b0000100);
        add_vec("lui",     32'h12345437, 32'hA, 32'hB, 1'b0, 5'd0, 32'h0,
                32'hA, 32'hB, 32'h12345000, 5'd8, 4'h0, 7'b1001000);
        add_vec("auipc",   32'hFFFFF497, 32'hC, 32'hD, 1'b0, 5'd0, 32'h0,
                32'hC, 32'hD, 32'hFFFFF000, 5'd9, 4'h0, 7'b1001000);
        add_vec("jal",     32'hFFDFF0EF, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                32'h1, 32'h2, 32'hFFFFFFFC, 5'd1, 4'h0, 7'b0001010);
        add_vec("jalr_x0", 32'h00008067, 32'h40, 32'h77, 1'b0, 5'd0, 32'h0,
                32'h40, 32'h0, 32'h0, 5'd0, 4'h0, 7'b1000010);
        add_vec("illegal", 32'h000001FF, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0, 32'h0, 5'd3, 4'h0, 7'b0000001);
        add_vec("nop",     32'h00000013, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0, 32'h0, 5'd0, 4'h0, 7'b1000000);
        add_vec("slli",    32'h01F09093, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0,
                32'h3, 32'h4, 32'd31, 5'd1, 4'h1, 7'b1001000);

        // Back-to-back table, one instruction per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].instr, 32'h100 + 32'(i) * 32'd4, vecs[i].rs1d, vecs[i].rs2d);
            wb_we = vecs[i].wbwe; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbdata;
            @(posedge clk);
            #1;
            chk({vecs[i].name, "/valid"}, 32'(ex_valid), 32'd1);
            chk({vecs[i].name, "/pc"},    ex_pc, 32'h100 + 32'(i) * 32'd4);
            chk({vecs[i].name, "/rs1"},   ex_rs1_val, vecs[i].e_rs1);
            chk({vecs[i].name, "/rs2"},   ex_rs2_val, vecs[i].e_rs2);
            chk({vecs[i].name, "/imm"},   ex_imm, vecs[i].e_imm);
            chk({vecs[i].name, "/rd"},    32'(ex_rd), 32'(vecs[i].e_rd));
            chk({vecs[i].name, "/alu"},   32'(ex_alu_op), 32'(vecs[i].e_alu));
            chk({vecs[i].name, "/ctrl"},  32'(ctrl_now()), 32'(vecs[i].e_ctrl));
        end
        chk("table_no_bubble", bubble_count, 32'd0);

        // Load-use: LW x5 then ADD x6,x5,x5
        @(negedge clk);
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        drive(32'h00812283, 32'h300, 32'h1000, 32'h0);
        @(posedge clk);
        #1;
        chk("lu_lw_in_ex", 32'(ex_mem_read), 32'd1);
        @(negedge clk);
        drive(32'h00528333, 32'h304, 32'd7, 32'd7);
        #1;
        chk("lu_if_ready_stall", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_count", bubble_count, 32'd1);
        @(posedge clk);
        #1;
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rd", 32'(ex_rd), 32'd6);
        chk("lu_add_pc", ex_pc, 32'h304);
        chk("lu_add_rs1", ex_rs1_val, 32'd7);
        chk("lu_count_hold", bubble_count, 32'd1);

        // Hold BEQ -8 under back-pressure, then seamless replace
        @(negedge clk);
        drive(32'hFE208CE3, 32'h400, 32'h3, 32'h4);
        @(posedge clk);
        #1;
        chk("hold_beq_imm", ex_imm, 32'hFFFFFFF8);
        @(negedge clk);
        ex_ready = 1'b0;
        drive(32'h00500093, 32'h404, 32'h0, 32'h0);
        #1;
        chk("hold_if_ready", 32'(if_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(ex_valid), 32'd1);
            chk("hold_imm", ex_imm, 32'hFFFFFFF8);
            chk("hold_pc", ex_pc, 32'h400);
            chk("hold_ctrl", 32'(ctrl_now()), 32'(7'b0000100));
            chk("hold_if_ready_cyc", 32'(if_ready), 32'd0);
        end
        @(negedge clk);
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("replace_valid", 32'(ex_valid), 32'd1);
        chk("replace_pc", ex_pc, 32'h404);
        chk("replace_imm", ex_imm, 32'd5);
        chk("replace_rd", 32'(ex_rd), 32'd1);
        chk("replace_ctrl", 32'(ctrl_now()), 32'(7'b1001000));

        // Flush while holding: drops held and incoming instruction
        @(negedge clk);
        ex_ready = 1'b0;
        flush    = 1'b1;
        drive(32'h12345437, 32'h408, 32'h0, 32'h0);
        #1;
        chk("flush_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_flush_valid", 32'(ex_valid), 32'd0);

        // Async reset between edges
        @(negedge clk);
        drive(32'h00500093, 32'h500, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        chk("pre_rst_bubble", bubble_count, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_bubble", bubble_count, 32'd0);
        chk("async_rst_imm", ex_imm, 32'd0);
        chk("async_rst_pc", ex_pc, 32'd0);
        chk("async_rst_ctrl", 32'(ctrl_now()), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_accept", 32'(ex_valid), 32'd1);
        chk("post_rst_pc", ex_pc, 32'h500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
